// File: rtl/key_event_ctrl.sv
// Key press/release (and optional long-press) events, round-robin queued.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_event_ctrl #(
  parameter int N_KEYS     = 4,
  parameter int LONG_MS    = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_1KHz,
  input  logic                        rst,
  input  logic [N_KEYS-1:0]           key_lvl,
  output logic                        ev_valid,
  output logic [$clog2(N_KEYS)-1:0]   ev_key,
  output logic [1:0]                  ev_type,
  input  logic                        ev_ready,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        overflow
);
  localparam int KW = $clog2(N_KEYS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [KW-1:0] LAST_K = KW'(N_KEYS - 1);
  localparam logic [1:0] T_PRESS = 2'b00;
  localparam logic [1:0] T_REL = 2'b01;
  localparam logic [1:0] T_LONG = 2'b10;

  if (N_KEYS < 2 || N_KEYS > 8 || LONG_MS < 2 || LONG_MS > 1023 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("key_event_ctrl: parameter out of range");
  end

  logic [N_KEYS-1:0] prev_q;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] rel_q, rel_d;
  logic [N_KEYS-1:0] pe, re, anyp, long_p;
  logic [N_KEYS-1:0] sel_oh, gnt_oh;
  logic [N_KEYS-1:0] g_press, g_rel, g_long;
  logic [KW-1:0]     rr_q, rr_d, sel;
  logic              found, push, pop;
  logic              long_ovf, ovf_q, ovf_d;
  logic [1:0]        wr_type;

  logic [KW-1:0]     mem_key [FIFO_DEPTH];
  logic [1:0]        mem_type [FIFO_DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;

  assign pe   = key_lvl & ~prev_q;
  assign re   = ~key_lvl & prev_q;
  assign anyp = press_q | long_p | rel_q;

  // First key with pending work at or after rr_q, wrapping.
  always_comb begin : p_arb
    int j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int i = 0; i < N_KEYS; i++) begin
      j = int'(rr_q) + i;
      if (j >= N_KEYS) j = j - N_KEYS;
      if (!found && anyp[j[KW-1:0]]) begin
        found = 1'b1;
        sel   = j[KW-1:0];
      end
    end
  end

  always_comb begin
    wr_type = T_REL;
    if (press_q[sel]) wr_type = T_PRESS;
    else if (long_p[sel]) wr_type = T_LONG;
  end

  assign push    = found && (cnt_q < DEPTH_C);
  assign pop     = ev_valid && ev_ready;
  assign sel_oh  = N_KEYS'(1) << sel;
  assign gnt_oh  = push ? sel_oh : '0;
  assign g_press = gnt_oh & {N_KEYS{wr_type == T_PRESS}};
  assign g_rel   = gnt_oh & {N_KEYS{wr_type == T_REL}};
  assign g_long  = gnt_oh & {N_KEYS{wr_type == T_LONG}};

  assign press_d = (press_q & ~g_press) | pe;
  assign rel_d   = (rel_q & ~g_rel) | re;
  assign rr_d    = !push ? rr_q : (sel == LAST_K) ? '0 : sel + 1'b1;
  assign ovf_d   = ovf_q | (|(pe & press_q & ~g_press))
                 | (|(re & rel_q & ~g_rel)) | long_ovf;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [9:0] HIT = 10'(LONG_MS - 1);
  logic [9:0]        lc_q [N_KEYS];
  logic [9:0]        lc_d [N_KEYS];
  logic [N_KEYS-1:0] long_q, long_d, le;

  // Counter parks at HIT, so one hold raises at most one long event.
  always_comb begin
    le = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      lc_d[k] = lc_q[k];
      if (pe[k] || !key_lvl[k]) begin
        lc_d[k] = '0;
      end else if (lc_q[k] != HIT) begin
        lc_d[k] = lc_q[k] + 10'd1;
        le[k]   = (lc_d[k] == HIT);
      end
    end
  end

  assign long_d   = (long_q & ~g_long) | le;
  assign long_p   = long_q;
  assign long_ovf = |(le & long_q & ~g_long);

  always_ff @(posedge clk_1KHz) begin
    if (rst) begin
      long_q <= '0;
      for (int k = 0; k < N_KEYS; k++) lc_q[k] <= '0;
    end else begin
      long_q <= long_d;
      lc_q   <= lc_d;
    end
  end
`else
  assign long_p   = '0;
  assign long_ovf = 1'b0;
`endif

  always_ff @(posedge clk_1KHz) begin
    prev_q <= key_lvl;
    if (rst) begin
      press_q <= '0;
      rel_q   <= '0;
      rr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      rel_q   <= rel_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_1KHz) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_key[wp_q]  <= sel;
        mem_type[wp_q] <= wr_type;
        wp_q           <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign ev_valid = (cnt_q != '0);
  assign ev_key   = ev_valid ? mem_key[rp_q] : '0;
  assign ev_type  = ev_valid ? mem_type[rp_q] : T_PRESS;
  assign ev_count = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random traffic
// checked against an event-level queue model.
module tb_key_event_ctrl;
  localparam int NK  = 4;
  localparam int LMS = 20;
  localparam int DEP = 4;

  logic       clk_1KHz = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_lvl = '0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_key;
  logic [1:0] ev_type;
  logic [2:0] ev_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  key_event_ctrl #(
    .N_KEYS(NK), .LONG_MS(LMS), .FIFO_DEPTH(DEP)
  ) dut (
    .clk_1KHz(clk_1KHz), .rst(rst), .key_lvl(key_lvl),
    .ev_valid(ev_valid), .ev_key(ev_key), .ev_type(ev_type),
    .ev_ready(ev_ready), .ev_count(ev_count), .overflow(overflow)
  );

  always #5 clk_1KHz = ~clk_1KHz;

  // Model: pending flags per key (0 press, 1 long, 2 release) and a queue
  bit         m_pend [NK][3];
  int         m_held [NK];
  bit         m_prev [NK];
  int         m_rr;
  bit         m_ovf;
  logic [3:0] m_q [$];

  function automatic logic [1:0] code(input int p);
    return (p == 0) ? 2'b00 : (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic void post(input int i, input int p);
    if (m_pend[i][p]) m_ovf = 1'b1;
    else m_pend[i][p] = 1'b1;
  endfunction

  function automatic void model_step(input logic [3:0] k,
                                     input bit rdy, input bit rs);
    int sz;
    int i;
    bit done;
    if (rs) begin
      m_q.delete();
      m_rr  = 0;
      m_ovf = 1'b0;
      for (int a = 0; a < NK; a++) begin
        m_prev[a] = k[a];
        m_held[a] = 0;
        for (int p = 0; p < 3; p++) m_pend[a][p] = 1'b0;
      end
      return;
    end
    sz = m_q.size();
    if (sz > 0 && rdy) void'(m_q.pop_front());
    done = 1'b0;
    if (sz < DEP) begin
      for (int n = 0; n < NK; n++) begin
        i = (m_rr + n) % NK;
        for (int p = 0; p < 3; p++) begin
          if (!done && m_pend[i][p]) begin
            m_q.push_back({2'(i), code(p)});
            m_pend[i][p] = 1'b0;
            m_rr = (i + 1) % NK;
            done = 1'b1;
          end
        end
      end
    end
    for (int a = 0; a < NK; a++) begin
      if (k[a] && !m_prev[a]) begin
        post(a, 0);
        m_held[a] = 0;
      end else if (k[a]) begin
        m_held[a]++;
`ifdef KEY_LONG_PRESS_EN
        if (m_held[a] == LMS - 1) post(a, 1);
`endif
      end else begin
        if (m_prev[a]) post(a, 2);
        m_held[a] = 0;
      end
      m_prev[a] = k[a];
    end
  endfunction

  task automatic tick(input logic [3:0] k, input logic rdy, input logic rs);
    key_lvl  = k;
    ev_ready = rdy;
    rst      = rs;
    @(posedge clk_1KHz);
    model_step(k, rdy, rs);
    #1;
  endtask

  task automatic do_reset();
    tick(4'b0000, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid got=%b exp=0", ev_valid);
    end
    n_checks++;
    if (ev_count !== 3'd0) begin
      n_errors++; $display("FAIL reset_count got=%0d exp=0", ev_count);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++; $display("FAIL reset_ovf got=%b exp=0", overflow);
    end
    n_checks++;
    if ({ev_key, ev_type} !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_head got=%0d/%b exp=0/00", ev_key, ev_type);
    end
  endtask

  task automatic test_single();
    for (int c = 1; c < 10; c++) tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0010, 1'b1, 1'b0);
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_early got=%b exp=0", ev_valid);
    end
    tick(4'b0010, 1'b1, 1'b0);
    n_checks++;
    if ({ev_valid, ev_key, ev_type} !== 5'b1_01_00) begin
      n_errors++;
      $display("FAIL single_press got=%b/%0d/%b exp=1/1/00",
               ev_valid, ev_key, ev_type);
    end
    tick(4'b0010, 1'b1, 1'b0);
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_once got=%b exp=0", ev_valid);
    end
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    n_checks++;
    if ({ev_valid, ev_key, ev_type} !== 5'b1_01_01) begin
      n_errors++;
      $display("FAIL single_release got=%b/%0d/%b exp=1/1/01",
               ev_valid, ev_key, ev_type);
    end
    tick(4'b0000, 1'b1, 1'b0);
  endtask

  // Follows test_single, which leaves the round-robin pointer at key 2
  task automatic test_round_robin();
    logic [1:0] exp_k [3];
    exp_k[0] = 2'd2; exp_k[1] = 2'd3; exp_k[2] = 2'd0;
    tick(4'b1101, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick(4'b1101, 1'b0, 1'b0);
      n_checks++;
      if (ev_count !== 3'(c)) begin
        n_errors++; $display("FAIL rr_fill got=%0d exp=%0d", ev_count, c);
      end
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({ev_valid, ev_key, ev_type} !== {1'b1, exp_k[c], 2'b00}) begin
        n_errors++;
        $display("FAIL rr_order%0d got=%b/%0d/%b exp=1/%0d/00",
                 c, ev_valid, ev_key, ev_type, exp_k[c]);
      end
      tick(4'b1101, 1'b1, 1'b0);
    end
    n_checks++;
    if (ev_valid !== 1'b0) begin
      n_errors++; $display("FAIL rr_empty got=%b exp=0", ev_valid);
    end
    do_reset();
  endtask

  task automatic test_long_press();
    int rec_t [$];
    logic [1:0] rec_ty [$];
    int exp_t [3];
    logic [1:0] exp_ty [3];
    int n_exp;
`ifdef KEY_LONG_PRESS_EN
    n_exp = 3;
    exp_t[0] = 2;  exp_ty[0] = 2'b00;
    exp_t[1] = 21; exp_ty[1] = 2'b10;
    exp_t[2] = 52; exp_ty[2] = 2'b01;
`else
    n_exp = 2;
    exp_t[0] = 2;  exp_ty[0] = 2'b00;
    exp_t[1] = 52; exp_ty[1] = 2'b01;
    exp_t[2] = 0;  exp_ty[2] = 2'b00;
`endif
    do_reset();
    for (int t = 1; t <= 60; t++) begin
      tick((t <= 50) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      if (ev_valid === 1'b1) begin
        rec_t.push_back(t);
        rec_ty.push_back(ev_type);
      end
    end
    n_checks++;
    if (rec_t.size() != n_exp) begin
      n_errors++;
      $display("FAIL long_count got=%0d exp=%0d", rec_t.size(), n_exp);
    end
    for (int i = 0; i < n_exp && i < rec_t.size(); i++) begin
      n_checks++;
      if (rec_t[i] != exp_t[i] || rec_ty[i] !== exp_ty[i]) begin
        n_errors++;
        $display("FAIL long_ev%0d got=t%0d/%b exp=t%0d/%b",
                 i, rec_t[i], rec_ty[i], exp_t[i], exp_ty[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_ty [4];
    exp_ty[0] = 2'b00; exp_ty[1] = 2'b01;
    exp_ty[2] = 2'b00; exp_ty[3] = 2'b01;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
    end
    n_checks++;
    if (ev_count !== 3'd4) begin
      n_errors++; $display("FAIL ovf_full got=%0d exp=4", ev_count);
    end
    tick(4'b0001, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    n_checks++;
    if ({overflow, ev_count} !== 4'b1_100) begin
      n_errors++;
      $display("FAIL ovf_flag got=%b/%0d exp=1/4", overflow, ev_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ev_valid, ev_key, ev_type} !== {3'b1_00, exp_ty[i]}) begin
        n_errors++;
        $display("FAIL ovf_drain%0d got=%b/%0d/%b exp=1/0/%b",
                 i, ev_valid, ev_key, ev_type, exp_ty[i]);
      end
      tick(4'b0000, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) tick(4'b0000, 1'b1, 1'b0);
    n_checks++;
    if ({overflow, ev_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL ovf_sticky got=%b/%b exp=1/0", overflow, ev_valid);
    end
  endtask

  task automatic test_hold_through_reset();
    int seen;
    seen = 0;
    for (int c = 0; c < 3; c++) tick(4'b0100, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick(4'b0100, 1'b1, 1'b0);
      if (ev_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++; $display("FAIL hold_nopress got=%0d exp=0", seen);
    end
    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    n_checks++;
    if ({ev_valid, ev_key, ev_type} !== 5'b1_10_01) begin
      n_errors++;
      $display("FAIL hold_release got=%b/%0d/%b exp=1/2/01",
               ev_valid, ev_key, ev_type);
    end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick(4'b0000, 1'b1, 1'b0);
      if (ev_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++; $display("FAIL hold_extra got=%0d exp=0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    tick(4'b0111, 1'b0, 1'b0);
    tick(4'b0111, 1'b0, 1'b0);
    tick(4'b0111, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0);
    n_checks++;
    if (ev_count !== 3'd3) begin
      n_errors++; $display("FAIL mid_pre got=%0d exp=3", ev_count);
    end
    tick(4'b0000, 1'b1, 1'b1);
    n_checks++;
    if ({ev_count, ev_valid, overflow} !== 5'b000_0_0) begin
      n_errors++;
      $display("FAIL mid_clear got=%0d/%b/%b exp=0/0/0",
               ev_count, ev_valid, overflow);
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick(4'b0000, 1'b1, 1'b0);
      if (ev_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++; $display("FAIL mid_stale got=%0d exp=0", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0] kv;
    bit rdy;
    bit rs;
    int rp;
    kv = '0;
    rp = 4;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) rp = $urandom_range(0, 4);
      for (int b = 0; b < NK; b++)
        if ($urandom_range(15) == 0) kv[b] = ~kv[b];
      rdy = ($urandom_range(3) < rp);
      rs  = ($urandom_range(399) == 0);
      tick(kv, rdy, rs);
      n_checks++;
      if (ev_count !== 3'(m_q.size())) begin
        n_errors++;
        $display("FAIL rnd_count c=%0d got=%0d exp=%0d",
                 c, ev_count, m_q.size());
      end
      n_checks++;
      if (overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, overflow, m_ovf);
      end
      n_checks++;
      if (ev_valid !== (m_q.size() != 0)) begin
        n_errors++;
        $display("FAIL rnd_valid c=%0d got=%b exp=%b",
                 c, ev_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        n_checks++;
        if ({ev_key, ev_type} !== m_q[0]) begin
          n_errors++;
          $display("FAIL rnd_head c=%0d got=%0d/%b exp=%0d/%b",
                   c, ev_key, ev_type, m_q[0][3:2], m_q[0][1:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_long_press();
    test_overflow();
    test_hold_through_reset();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
